// File: rtl/calc_pkg.sv
`default_nettype none
// ------------------------------------------------------------------------------
// calc_pkg: token codes, FSM/accumulator encodings and helpers for num_builder_fx
// Revision: 1.0
// ------------------------------------------------------------------------------
package calc_pkg;

   localparam logic [31:0] TOK_ADD    = 32'd10;
   localparam logic [31:0] TOK_SUB    = 32'd11;
   localparam logic [31:0] TOK_MUL    = 32'd12;
   localparam logic [31:0] TOK_DIV    = 32'd13;
   localparam logic [31:0] TOK_LPAREN = 32'd14;
   localparam logic [31:0] TOK_RPAREN = 32'd15;
   localparam logic [31:0] TOK_POINT  = 32'd16;
   localparam logic [31:0] TOK_E      = 32'd17;
   localparam logic [31:0] TOK_PI     = 32'd18;

   typedef enum logic [2:0] {
      ST_IDLE, ST_FETCH, ST_WAIT, ST_PROC, ST_SCALE, ST_EMIT, ST_DONE, ST_ERR
   } state_t;

   typedef enum logic [2:0] {
      ACC_NOP, ACC_CLR, ACC_DIGIT, ACC_POINT, ACC_SCALE
   } acc_op_t;

   typedef enum logic [1:0] {
      K_DIGIT, K_POINT, K_CONST, K_OPER
   } tok_kind_t;

   function automatic logic [63:0] mul10(input logic [63:0] x);
      return (x << 3) + (x << 1);
   endfunction

   // Codes below TOK_ADD are digits; anything unrecognised is passed through as an operator.
   function automatic tok_kind_t tok_kind(input logic [31:0] tok);
      tok_kind_t k;
      k = K_OPER;
      if (tok < TOK_ADD) begin
         k = K_DIGIT;
      end else begin
         case (tok)
            TOK_ADD, TOK_SUB, TOK_MUL, TOK_DIV, TOK_LPAREN, TOK_RPAREN: k = K_OPER;
            TOK_POINT:    k = K_POINT;
            TOK_E, TOK_PI: k = K_CONST;
            default:      k = K_OPER;
         endcase
      end
      return k;
   endfunction

endpackage
`default_nettype wire

// File: rtl/digit_accumulator.sv
`default_nettype none
// ------------------------------------------------------------------------------
// digit_accumulator: decimal accumulator with fraction count and point tracking
// Revision: 1.0
// ------------------------------------------------------------------------------
module digit_accumulator
   import calc_pkg::*;
#(
   parameter int PW          = 41,
   parameter int FRAC_DIGITS = 4
) (
   input  logic                               clock,
   input  logic                               reset,
   input  acc_op_t                            op_i,
   input  logic [3:0]                         digit_i,
   output logic [PW-1:0]                      acc_o,
   output logic [$clog2(FRAC_DIGITS+1)-1:0]   fcnt_o,
   output logic                               open_o,
   output logic                               dup_point_o,
   output logic                               ovf_o
);

   localparam int              FW          = $clog2(FRAC_DIGITS+1);
   localparam logic [63:0]     MAX_PAYLOAD = (64'd1 << PW) - 64'd1;
   localparam logic [FW-1:0]   FRAC_FULL   = FW'(FRAC_DIGITS);

   logic [PW-1:0] acc_q,   acc_d;
   logic [FW-1:0] fcnt_q,  fcnt_d;
   logic          point_q, point_d;
   logic          open_q,  open_d;

   logic [63:0]   w_next;
   logic          w_over;
   logic          w_drop;

   // acc*10+d > MAX is the same test as acc > (MAX-d)/10, without a divider.
   assign w_next = mul10(64'(acc_q)) + 64'(digit_i);
   assign w_over = (w_next > MAX_PAYLOAD);
   assign w_drop = point_q && (fcnt_q == FRAC_FULL);

   always_comb begin
      acc_d   = acc_q;
      fcnt_d  = fcnt_q;
      point_d = point_q;
      open_d  = open_q;
      ovf_o   = 1'b0;
      case (op_i)
         ACC_CLR: begin
            acc_d   = '0;
            fcnt_d  = '0;
            point_d = 1'b0;
            open_d  = 1'b0;
         end
         ACC_DIGIT: begin
            open_d = 1'b1;
            if (!w_drop) begin
               if (w_over) begin
                  ovf_o = 1'b1;
               end else begin
                  acc_d = w_next[PW-1:0];
                  if (point_q) fcnt_d = fcnt_q + FW'(1);
               end
            end
         end
         ACC_POINT: begin
            point_d = 1'b1;
            open_d  = 1'b1;
         end
         ACC_SCALE: begin
            if (w_over) begin
               ovf_o = 1'b1;
            end else begin
               acc_d  = w_next[PW-1:0];
               fcnt_d = fcnt_q + FW'(1);
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         acc_q   <= '0;
         fcnt_q  <= '0;
         point_q <= 1'b0;
         open_q  <= 1'b0;
      end else begin
         acc_q   <= acc_d;
         fcnt_q  <= fcnt_d;
         point_q <= point_d;
         open_q  <= open_d;
      end
   end

   assign acc_o       = acc_q;
   assign fcnt_o      = fcnt_q;
   assign open_o      = open_q;
   assign dup_point_o = point_q;

endmodule
`default_nettype wire

// File: rtl/num_builder_fx.sv
`default_nettype none
// ------------------------------------------------------------------------------
// num_builder_fx: compacts key-entry tokens into fixed-point numbers and operators
// Revision: 1.0
// ------------------------------------------------------------------------------
module num_builder_fx
   import calc_pkg::*;
#(
   parameter int DEPTH       = 12,
   parameter int WIDTH       = 8,
   parameter int NEWWIDTH    = 42,
   parameter int FRAC_DIGITS = 4,
   parameter int E_VAL       = 27183,
   parameter int PI_VAL      = 31416
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         start,
   input  logic [$clog2(DEPTH+1)-1:0]   len,
   output logic [$clog2(DEPTH)-1:0]     rd_addr,
   input  logic [WIDTH-1:0]             rd_data,
   output logic                         out_we,
   output logic [$clog2(DEPTH)-1:0]     out_addr,
   output logic [NEWWIDTH-1:0]          out_data,
   output logic [$clog2(DEPTH+1)-1:0]   out_count,
   output logic                         busy,
   output logic                         done,
   output logic                         error
);

   localparam int            AW         = $clog2(DEPTH);
   localparam int            LW         = $clog2(DEPTH+1);
   localparam int            PW         = NEWWIDTH - 1;
   localparam int            FW         = $clog2(FRAC_DIGITS+1);
   localparam logic [FW-1:0] FRAC_FULL  = FW'(FRAC_DIGITS);
   localparam logic [FW-1:0] FRAC_LAST  = FW'(FRAC_DIGITS - 1);
   localparam logic [LW-1:0] DEPTH_L    = LW'(DEPTH);

   state_t              state_q;
   logic [LW-1:0]       len_q;
   logic [LW-1:0]       idx_q;
   logic                flush_q;
   logic                pend_valid_q;
   logic [NEWWIDTH-1:0] pend_data_q;
   logic                out_we_q;
   logic [AW-1:0]       out_addr_q;
   logic [NEWWIDTH-1:0] out_data_q;
   logic [LW-1:0]       out_count_q;
   logic                busy_q;
   logic                done_q;
   logic                error_q;

   tok_kind_t           w_kind;
   logic [3:0]          w_digit;
   logic [NEWWIDTH-1:0] w_pend;
   acc_op_t             w_acc_op;
   logic [PW-1:0]       w_acc;
   logic [FW-1:0]       w_fcnt;
   logic                w_open;
   logic                w_dup;
   logic                w_ovf;

   assign w_kind  = tok_kind(32'(rd_data));
   assign w_digit = (state_q == ST_PROC && w_kind == K_DIGIT) ? rd_data[3:0] : 4'd0;

   always_comb begin
      w_pend = {1'b0, PW'(rd_data)};
      if (32'(rd_data) == TOK_E)       w_pend = {1'b1, PW'(E_VAL)};
      else if (32'(rd_data) == TOK_PI) w_pend = {1'b1, PW'(PI_VAL)};
   end

   always_comb begin
      w_acc_op = ACC_NOP;
      case (state_q)
         ST_IDLE:  if (start) w_acc_op = ACC_CLR;
         ST_PROC: begin
            if (w_kind == K_DIGIT)                 w_acc_op = ACC_DIGIT;
            else if (w_kind == K_POINT && !w_dup)  w_acc_op = ACC_POINT;
         end
         ST_SCALE: w_acc_op = ACC_SCALE;
         ST_EMIT:  if (w_open && out_count_q != DEPTH_L) w_acc_op = ACC_CLR;
         default:  ;
      endcase
   end

   digit_accumulator #(
      .PW          (PW),
      .FRAC_DIGITS (FRAC_DIGITS)
   ) u_acc (
      .clock       (clock),
      .reset       (reset),
      .op_i        (w_acc_op),
      .digit_i     (w_digit),
      .acc_o       (w_acc),
      .fcnt_o      (w_fcnt),
      .open_o      (w_open),
      .dup_point_o (w_dup),
      .ovf_o       (w_ovf)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         len_q        <= '0;
         idx_q        <= '0;
         flush_q      <= 1'b0;
         pend_valid_q <= 1'b0;
         pend_data_q  <= '0;
         out_we_q     <= 1'b0;
         out_addr_q   <= '0;
         out_data_q   <= '0;
         out_count_q  <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
      end else begin
         out_we_q <= 1'b0;
         done_q   <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  len_q        <= len;
                  idx_q        <= '0;
                  flush_q      <= 1'b0;
                  pend_valid_q <= 1'b0;
                  out_count_q  <= '0;
                  error_q      <= 1'b0;
                  busy_q       <= 1'b1;
                  state_q      <= ST_FETCH;
               end
            end
            ST_FETCH: begin
               if (idx_q < len_q) begin
                  state_q <= ST_WAIT;
               end else begin
                  flush_q <= 1'b1;
                  if (!w_open)                  state_q <= ST_DONE;
                  else if (w_fcnt == FRAC_FULL) state_q <= ST_EMIT;
                  else                          state_q <= ST_SCALE;
               end
            end
            ST_WAIT: state_q <= ST_PROC;
            ST_PROC: begin
               idx_q <= idx_q + LW'(1);
               case (w_kind)
                  K_DIGIT: state_q <= w_ovf ? ST_ERR : ST_FETCH;
                  K_POINT: state_q <= w_dup ? ST_ERR : ST_FETCH;
                  default: begin
                     // Any open number is scaled and written before this entry.
                     pend_valid_q <= 1'b1;
                     pend_data_q  <= w_pend;
                     state_q      <= (w_open && w_fcnt != FRAC_FULL) ? ST_SCALE : ST_EMIT;
                  end
               endcase
            end
            ST_SCALE: begin
               if (w_ovf)                    state_q <= ST_ERR;
               else if (w_fcnt == FRAC_LAST) state_q <= ST_EMIT;
            end
            ST_EMIT: begin
               if (out_count_q == DEPTH_L) begin
                  state_q <= ST_ERR;
               end else begin
                  out_we_q    <= 1'b1;
                  out_addr_q  <= out_count_q[AW-1:0];
                  out_count_q <= out_count_q + LW'(1);
                  if (w_open) begin
                     out_data_q <= {1'b1, w_acc};
                     if (!pend_valid_q) state_q <= flush_q ? ST_DONE : ST_FETCH;
                  end else begin
                     out_data_q   <= pend_data_q;
                     pend_valid_q <= 1'b0;
                     state_q      <= flush_q ? ST_DONE : ST_FETCH;
                  end
               end
            end
            ST_ERR: begin
               error_q <= 1'b1;
               state_q <= ST_DONE;
            end
            ST_DONE: begin
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign rd_addr   = idx_q[AW-1:0];
   assign out_we    = out_we_q;
   assign out_addr  = out_addr_q;
   assign out_data  = out_data_q;
   assign out_count = out_count_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign error     = error_q;

endmodule
`default_nettype wire

// File: tb/tb_num_builder_fx.sv
`default_nettype none
// ------------------------------------------------------------------------------
// tb_num_builder_fx: directed and random token streams against a behavioural model
// Revision: 1.0
// ------------------------------------------------------------------------------
module tb_num_builder_fx;

   localparam int     DEPTH = 12;
   localparam int     FRAC  = 4;
   localparam longint MAXP  = (longint'(1) << 41) - 1;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        start_b = 1'b0;
   logic [3:0]  len = '0;
   logic [3:0]  len_b = '0;
   logic [3:0]  rd_addr, rd_addr_b;
   logic [7:0]  rd_data, rd_data_b;
   logic        out_we, out_we_b;
   logic [3:0]  out_addr, out_addr_b;
   logic [41:0] out_data;
   logic [15:0] out_data_b;
   logic [3:0]  out_count, out_count_b;
   logic        busy, busy_b, done, done_b, error, error_b;

   logic [7:0]  mem [16];

   num_builder_fx dut (
      .clock(clock), .reset(reset), .start(start), .len(len),
      .rd_addr(rd_addr), .rd_data(rd_data), .out_we(out_we), .out_addr(out_addr),
      .out_data(out_data), .out_count(out_count), .busy(busy), .done(done), .error(error)
   );

   num_builder_fx #(.NEWWIDTH(16)) dut_narrow (
      .clock(clock), .reset(reset), .start(start_b), .len(len_b),
      .rd_addr(rd_addr_b), .rd_data(rd_data_b), .out_we(out_we_b), .out_addr(out_addr_b),
      .out_data(out_data_b), .out_count(out_count_b), .busy(busy_b), .done(done_b), .error(error_b)
   );

   always #5 clock = ~clock;

   always @(posedge clock) begin
      rd_data   <= mem[rd_addr];
      rd_data_b <= mem[rd_addr_b];
   end

   logic [41:0] obs_data[$];
   int          obs_addr[$];
   int          writes_b = 0;

   always @(negedge clock) begin
      if (out_we) begin
         obs_data.push_back(out_data);
         obs_addr.push_back(int'(out_addr));
      end
      if (out_we_b) writes_b++;
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
      end
   endtask

   // Reference model: parse the token list as decimal text and scale each number.
   logic [41:0] exp_q[$];
   bit          exp_err;
   longint      m_acc;
   int          m_fc;
   bit          m_open, m_pt;

   task automatic m_push(input logic [41:0] e);
      if (exp_q.size() == DEPTH) exp_err = 1'b1;
      else exp_q.push_back(e);
   endtask

   task automatic m_close();
      longint scaled;
      scaled = m_acc;
      for (int k = m_fc; k < FRAC; k++) scaled = scaled * 10;
      if (scaled > MAXP) exp_err = 1'b1;
      else m_push({1'b1, 41'(scaled)});
      m_acc = 0; m_fc = 0; m_open = 1'b0; m_pt = 1'b0;
   endtask

   task automatic model(input int toks[$]);
      int t;
      exp_q.delete();
      exp_err = 1'b0; m_acc = 0; m_fc = 0; m_open = 1'b0; m_pt = 1'b0;
      foreach (toks[i]) begin
         if (exp_err) break;
         t = toks[i];
         if (t < 10) begin
            m_open = 1'b1;
            if (!(m_pt && m_fc == FRAC)) begin
               if (m_acc * 10 + t > MAXP) exp_err = 1'b1;
               else begin
                  m_acc = m_acc * 10 + t;
                  if (m_pt) m_fc++;
               end
            end
         end else if (t == 16) begin
            if (m_pt) exp_err = 1'b1;
            else begin m_pt = 1'b1; m_open = 1'b1; end
         end else begin
            if (m_open) m_close();
            if (!exp_err) begin
               if (t == 17)      m_push({1'b1, 41'd27183});
               else if (t == 18) m_push({1'b1, 41'd31416});
               else              m_push({1'b0, 41'(t)});
            end
         end
      end
      if (!exp_err && m_open) m_close();
   endtask

   // Called on a negedge with the DUT idle; returns on a negedge.
   task automatic run_case(input string name, input int toks[$]);
      int lat;
      int n;
      for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
      foreach (toks[i]) mem[i] = 8'(toks[i]);
      model(toks);
      obs_data.delete();
      obs_addr.delete();
      len   = 4'(toks.size());
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      lat   = 1;
      check_eq({name, "/busy"}, busy, 1);
      while (!done && lat < 400) begin
         @(negedge clock);
         lat++;
      end
      check_eq({name, "/done_seen"}, done, 1);
      if (toks.size() == 0) check_eq({name, "/len0_latency"}, lat - 1, 2);
      check_eq({name, "/error"}, error, exp_err);
      check_eq({name, "/out_count"}, out_count, exp_q.size());
      check_eq({name, "/n_writes"}, obs_data.size(), exp_q.size());
      n = (obs_data.size() < exp_q.size()) ? obs_data.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         check_eq($sformatf("%s/data%0d", name, i), obs_data[i], exp_q[i]);
         check_eq($sformatf("%s/addr%0d", name, i), obs_addr[i], i);
      end
      @(negedge clock);
      check_eq({name, "/done_pulse"}, done, 0);
      check_eq({name, "/idle_busy"}, busy, 0);
      check_eq({name, "/error_sticky"}, error, exp_err);
      check_eq({name, "/count_held"}, out_count, exp_q.size());
   endtask

   function automatic int rand_tok();
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 55) return int'($urandom_range(0, 9));
      if (r < 63) return 16;
      if (r < 69) return 17;
      if (r < 75) return 18;
      if (r < 92) return int'($urandom_range(10, 15));
      return int'($urandom_range(19, 255));
   endfunction

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int q[$];
      int lat;
      for (int i = 0; i < 16; i++) mem[i] = 8'd0;
      repeat (2) @(negedge clock);
      check_eq("reset/outs",
               {busy, done, error, out_we, out_count, out_addr, out_data, rd_addr}, 0);
      reset = 1'b0;
      @(negedge clock);

      q = '{17, 11, 2, 16, 3, 10, 4, 16, 2, 2};
      run_case("tp_mixed", q);
      q = '{16, 5, 12, 7, 16};
      run_case("tp_points", q);
      q = '{1, 16, 2, 16};
      run_case("tp_dup_point", q);
      q.delete();
      run_case("tp_len0", q);
      q = '{3, 16, 1, 4, 1, 5, 9};
      run_case("tp_trunc", q);
      q = '{17, 2};
      run_case("tp_e2", q);
      q = '{16};
      run_case("tp_lone_point", q);
      q = '{9, 9, 9, 9, 9, 9, 9, 9, 9, 9, 9, 9};
      run_case("tp_scale_ovf", q);

      // Narrow payload instance: five 9s exceed 2^15-1.
      for (int i = 0; i < 6; i++) mem[i] = 8'd9;
      len_b   = 4'd6;
      start_b = 1'b1;
      @(negedge clock);
      start_b = 1'b0;
      lat = 1;
      while (!done_b && lat < 400) begin
         @(negedge clock);
         lat++;
      end
      check_eq("narrow/done_seen", done_b, 1);
      check_eq("narrow/error", error_b, 1);
      check_eq("narrow/out_count", out_count_b, 0);
      check_eq("narrow/writes", writes_b, 0);
      @(negedge clock);

      // Reset while the trailing number of "5" is being scaled.
      mem[0] = 8'd5;
      len    = 4'd1;
      start  = 1'b1;
      @(negedge clock);
      start  = 1'b0;
      repeat (5) @(negedge clock);
      check_eq("rst_mid/busy_before", busy, 1);
      reset = 1'b1;
      #1;
      check_eq("rst_mid/outs",
               {busy, done, error, out_we, out_count, out_addr, out_data, rd_addr}, 0);
      @(negedge clock);
      reset = 1'b0;
      obs_data.delete();
      obs_addr.delete();
      repeat (10) @(negedge clock);
      check_eq("rst_mid/no_writes", obs_data.size(), 0);
      check_eq("rst_mid/idle", busy, 0);
      q = '{18, 13, 2};
      run_case("after_rst", q);

      for (int n = 0; n < 40; n++) begin
         int l;
         q.delete();
         l = int'($urandom_range(0, 12));
         for (int i = 0; i < l; i++) q.push_back(rand_tok());
         run_case($sformatf("rnd%0d", n), q);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
